// File: rtl/sram_outstanding_tracker_pkg.sv
// Shared sizing defaults and helpers for the SRAM outstanding-request tracker.
package sram_outstanding_tracker_pkg;

  localparam int unsigned TRK_DEPTH_DEF  = 2;
  localparam int unsigned TRK_TAG_W_DEF  = 32;
  localparam int unsigned TRK_DATA_W_DEF = 32;

  // Pointer width that stays legal for a single-entry ring.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_outstanding_tracker_trk_ring.sv
// In-order ring of DEPTH {discard, tag} entries with pointers, occupancy count
// and a flush port that marks every live entry as discard.
module trk_ring
  import sram_outstanding_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = TRK_DEPTH_DEF,
  parameter int unsigned TAG_W = TRK_TAG_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [TAG_W-1:0]             push_tag_i,
  input  logic                         push_dis_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [TAG_W-1:0]             head_tag_o,
  output logic                         head_dis_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         live_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0]            dis_q, dis_d;
  logic [PTR_W-1:0]            wr_q, wr_d;
  logic [PTR_W-1:0]            rd_q, rd_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  // Flush marks first, then pop frees the head and push writes the tail.
  always_comb begin
    tag_d = tag_q;
    vld_d = vld_q;
    dis_d = dis_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush_i) begin
      dis_d = dis_q | vld_q;
    end
    if (pop_i) begin
      vld_d[rd_q] = 1'b0;
      dis_d[rd_q] = 1'b0;
      rd_d        = ptr_inc(rd_q);
    end
    if (push_i) begin
      tag_d[wr_q] = push_tag_i;
      vld_d[wr_q] = 1'b1;
      dis_d[wr_q] = push_dis_i;
      wr_d        = ptr_inc(wr_q);
    end
    cnt_d = CNT_W'(cnt_q + CNT_W'(push_i) - CNT_W'(pop_i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
      vld_q <= '0;
      dis_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      vld_q <= vld_d;
      dis_q <= dis_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_tag_o = tag_q[rd_q];
  assign head_dis_o = dis_q[rd_q];
  assign count_o    = cnt_q;
  assign live_o     = |(vld_q & ~dis_q);

endmodule

// File: rtl/sram_outstanding_tracker.sv
// Tracks in-flight requests on one SRAM req/addr_ok/data_ok channel, dropping
// responses of requests that were in flight when the pipeline flushed.
module sram_outstanding_tracker
  import sram_outstanding_tracker_pkg::*;
#(
  parameter int unsigned DEPTH  = TRK_DEPTH_DEF,
  parameter int unsigned TAG_W  = TRK_TAG_W_DEF,
  parameter int unsigned DATA_W = TRK_DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       addr_ok,
  input  logic [TAG_W-1:0]           req_tag,
  input  logic                       data_ok,
  input  logic [DATA_W-1:0]          rdata,
  input  logic                       flush,
  output logic                       req_allow,
  output logic                       resp_valid,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       busy_live,
  output logic                       proto_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] cnt;
  logic             head_dis;
  logic             empty;
  logic             accept;
  logic             acc_full;
  logic             pop;
  logic             proto_err_q, proto_err_d;

  // req_allow looks only at registered count, so data_ok never reaches it.
  assign empty     = (cnt == '0);
  assign req_allow = (cnt != CNT_W'(DEPTH));
  assign accept    = req & addr_ok & req_allow;
  assign acc_full  = req & addr_ok & ~req_allow;
  assign pop       = data_ok & ~empty;

  assign resp_valid  = pop & ~head_dis & ~flush;
  assign resp_rdata  = rdata;
  assign outstanding = cnt;

  always_comb begin
    proto_err_d = proto_err_q | (data_ok & empty) | acc_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

  trk_ring #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .push_i     (accept),
    .push_tag_i (req_tag),
    .push_dis_i (flush),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_tag_o (resp_tag),
    .head_dis_o (head_dis),
    .count_o    (cnt),
    .live_o     (busy_live)
  );

endmodule

// File: tb/tb_sram_outstanding_tracker.sv
// Bench: DEPTH=2 and DEPTH=3 trackers on shared stimulus, checked against an
// ordered-list model of in-flight requests.
module tb_sram_outstanding_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req2, req3, addr_ok, data_ok, flush;
  logic [31:0] req_tag, rdata;

  logic        allow2, rv2, live2, perr2;
  logic [31:0] rtag2, rdat2;
  logic [1:0]  out2;
  logic        allow3, rv3, live3, perr3;
  logic [31:0] rtag3, rdat3;
  logic [1:0]  out3;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit chk_en = 1'b0;

  // Reference: per tracker, an oldest-first list of {discard, tag}.
  int          dep   [2] = '{2, 3};
  logic [31:0] mtag  [2][4];
  bit          mdis  [2][4];
  int          mcnt  [2] = '{0, 0};
  bit          mperr [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  sram_outstanding_tracker #(.DEPTH(2), .TAG_W(32), .DATA_W(32)) u_d2 (
    .clk(clk), .reset(reset), .req(req2), .addr_ok(addr_ok), .req_tag(req_tag),
    .data_ok(data_ok), .rdata(rdata), .flush(flush), .req_allow(allow2),
    .resp_valid(rv2), .resp_tag(rtag2), .resp_rdata(rdat2), .outstanding(out2),
    .busy_live(live2), .proto_err(perr2)
  );

  sram_outstanding_tracker #(.DEPTH(3), .TAG_W(32), .DATA_W(32)) u_d3 (
    .clk(clk), .reset(reset), .req(req3), .addr_ok(addr_ok), .req_tag(req_tag),
    .data_ok(data_ok), .rdata(rdata), .flush(flush), .req_allow(allow3),
    .resp_valid(rv3), .resp_tag(rtag3), .resp_rdata(rdat3), .outstanding(out3),
    .busy_live(live3), .proto_err(perr3)
  );

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s depth%0d: got %h expected %h at %0t", name, dep[d], got, exp, $time);
    end
  endtask

  // Compare one tracker against the model, then advance the model by one edge.
  task automatic check_dut(input int d, input logic r, input logic allow,
                           input logic rv, input logic [31:0] rtag,
                           input logic [31:0] rdat, input logic [1:0] outs,
                           input logic live, input logic perr);
    bit allow_e, pop, rv_e, live_e, acc;
    allow_e = (mcnt[d] != dep[d]);
    pop     = data_ok && (mcnt[d] != 0);
    rv_e    = pop && !mdis[d][0] && !flush;
    live_e  = 1'b0;
    for (int i = 0; i < mcnt[d]; i++) if (!mdis[d][i]) live_e = 1'b1;
    chk("req_allow", d, 32'(allow), 32'(allow_e));
    chk("resp_valid", d, 32'(rv), 32'(rv_e));
    if (rv_e) begin
      chk("resp_tag", d, rtag, mtag[d][0]);
      chk("resp_rdata", d, rdat, rdata);
      delivered++;
    end
    chk("outstanding", d, 32'(outs), 32'(mcnt[d]));
    chk("busy_live", d, 32'(live), 32'(live_e));
    chk("proto_err", d, 32'(perr), 32'(mperr[d]));
    if (reset) begin
      mcnt[d]  = 0;
      mperr[d] = 1'b0;
    end else begin
      acc = r && addr_ok && allow_e;
      if (r && addr_ok && !allow_e) mperr[d] = 1'b1;
      if (data_ok && mcnt[d] == 0)  mperr[d] = 1'b1;
      if (flush) for (int i = 0; i < mcnt[d]; i++) mdis[d][i] = 1'b1;
      if (pop) begin
        for (int i = 0; i < 3; i++) begin
          mtag[d][i] = mtag[d][i+1];
          mdis[d][i] = mdis[d][i+1];
        end
        mcnt[d]--;
      end
      if (acc) begin
        mtag[d][mcnt[d]] = req_tag;
        mdis[d][mcnt[d]] = flush;
        mcnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, req2, allow2, rv2, rtag2, rdat2, out2, live2, perr2);
      check_dut(1, req3, allow3, rv3, rtag3, rdat3, out3, live3, perr3);
    end
  end

  task automatic cyc(input bit r, input bit ao, input logic [31:0] tg,
                     input bit dok, input logic [31:0] rd, input bit fl);
    @(posedge clk); #1;
    reset = 1'b0; req2 = r; req3 = r; addr_ok = ao; req_tag = tg;
    data_ok = dok; rdata = rd; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req2 = 0; req3 = 0; addr_ok = 0; req_tag = 0;
    data_ok = 0; rdata = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Single request, response three cycles later.
    cyc(1, 1, 32'hBFC00000, 0, 0, 0);
    chk("t1_out_before", 0, 32'(out2), 32'd0);
    chk("t1_allow", 0, 32'(allow2), 32'd1);
    idle();
    chk("t1_out_after", 0, 32'(out2), 32'd1);
    idle(); idle();
    cyc(0, 0, 0, 1, 32'h24010001, 0);
    chk("t1_rv", 0, 32'(rv2), 32'd1);
    chk("t1_tag", 0, rtag2, 32'hBFC00000);
    chk("t1_rdata", 0, rdat2, 32'h24010001);
    idle();
    chk("t1_rv_off", 0, 32'(rv2), 32'd0);
    chk("t1_out_end", 0, 32'(out2), 32'd0);

    // Fill DEPTH=2 and drain in order.
    cyc(1, 1, 32'h10000004, 0, 0, 0);
    cyc(1, 1, 32'h10000008, 0, 0, 0);
    idle();
    chk("t2_allow_full", 0, 32'(allow2), 32'd0);
    chk("t2_out_full", 0, 32'(out2), 32'd2);
    chk("t2_allow_d3", 1, 32'(allow3), 32'd1);
    cyc(0, 0, 0, 1, 32'h11, 0);
    chk("t2_tag_a", 0, rtag2, 32'h10000004);
    cyc(0, 0, 0, 1, 32'h22, 0);
    chk("t2_tag_b", 0, rtag2, 32'h10000008);
    chk("t2_rv_b", 0, 32'(rv2), 32'd1);
    idle();

    // Flush with two in flight; both responses dropped, next one delivered.
    cyc(1, 1, 32'hA0, 0, 0, 0);
    cyc(1, 1, 32'hB0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_live_pre", 0, 32'(live2), 32'd1);
    idle();
    chk("t3_live_post", 0, 32'(live2), 32'd0);
    chk("t3_out_held", 0, 32'(out2), 32'd2);
    cyc(0, 0, 0, 1, 32'h33, 0);
    chk("t3_drop1", 0, 32'(rv2), 32'd0);
    cyc(0, 0, 0, 1, 32'h44, 0);
    chk("t3_drop2", 0, 32'(rv2), 32'd0);
    cyc(1, 1, 32'hC0, 0, 0, 0);
    chk("t3_out_zero", 0, 32'(out2), 32'd0);
    cyc(0, 0, 0, 1, 32'h55, 0);
    chk("t3_rv_c", 0, 32'(rv2), 32'd1);
    chk("t3_tag_c", 0, rtag2, 32'hC0);

    // Accept with flush is discarded; accept with pop holds count.
    cyc(1, 1, 32'hD0, 0, 0, 1);
    idle();
    chk("t4_out_d", 0, 32'(out2), 32'd1);
    chk("t4_live_d", 0, 32'(live2), 32'd0);
    cyc(1, 1, 32'hE0, 1, 32'h66, 0);
    chk("t4_drop_d", 0, 32'(rv2), 32'd0);
    idle();
    chk("t4_out_held", 0, 32'(out2), 32'd1);
    chk("t4_live_e", 0, 32'(live2), 32'd1);
    cyc(0, 0, 0, 1, 32'h77, 0);
    chk("t4_tag_e", 0, rtag2, 32'hE0);
    chk("t4_rdata_e", 0, rdat2, 32'h77);
    cyc(1, 1, 32'hF0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h88, 1);
    chk("t4_flush_pop2", 0, 32'(rv2), 32'd0);
    chk("t4_flush_pop3", 1, 32'(rv3), 32'd0);
    idle();
    chk("t4_out_end", 0, 32'(out2), 32'd0);

    // Randomised traffic; each tracker gates its own req with req_allow.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      reset   = 1'b0;
      addr_ok = ($urandom_range(0, 9) < 7);
      req2    = ($urandom_range(0, 1) == 1) && allow2;
      req3    = ($urandom_range(0, 1) == 1) && allow3;
      req_tag = $urandom;
      data_ok = ($urandom_range(0, 1) == 1) && (mcnt[0] != 0) && (mcnt[1] != 0);
      rdata   = $urandom;
      flush   = ($urandom_range(0, 19) == 0);
    end
    idle();
    chk("t5_no_err2", 0, 32'(perr2), 32'd0);
    chk("t5_no_err3", 1, 32'(perr3), 32'd0);
    chk("t5_delivered", 0, 32'(delivered != 0), 32'd1);

    // data_ok on empty, accept while full, then reset mid-operation.
    repeat (4) cyc(0, 0, 0, 1, 32'h99, 0);
    idle();
    chk("t6_err2", 0, 32'(perr2), 32'd1);
    chk("t6_err3", 1, 32'(perr3), 32'd1);
    chk("t6_empty", 0, 32'(out2), 32'd0);
    cyc(1, 1, 32'h100, 0, 0, 0);
    cyc(1, 1, 32'h200, 0, 0, 0);
    cyc(1, 1, 32'h300, 0, 0, 0);
    idle();
    chk("t6_out2", 0, 32'(out2), 32'd2);
    chk("t6_out3", 1, 32'(out3), 32'd3);
    chk("t6_allow3", 1, 32'(allow3), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; req2 = 0; req3 = 0; addr_ok = 0; data_ok = 0; flush = 0;
    @(negedge clk); #1;
    idle();
    chk("t6_rst_out2", 0, 32'(out2), 32'd0);
    chk("t6_rst_out3", 1, 32'(out3), 32'd0);
    chk("t6_rst_err", 0, 32'(perr2), 32'd0);
    chk("t6_rst_allow", 0, 32'(allow2), 32'd1);
    chk("t6_rst_live", 0, 32'(live2), 32'd0);
    chk("t6_rst_rv", 0, 32'(rv2), 32'd0);
    cyc(0, 0, 0, 1, 32'hAA, 0);
    idle();
    chk("t6_late_err2", 0, 32'(perr2), 32'd1);
    chk("t6_late_err3", 1, 32'(perr3), 32'd1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
